// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, BCD limits and carry/borrow helpers for the digit chain controller
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // A digit passes a carry to its upper neighbour only when it sits at 9.
  function automatic logic carry_up(input logic [3:0] d);
    return d == BCD_MAX;
  endfunction

  // A digit passes a borrow to its upper neighbour only when it sits at 0.
  function automatic logic borrow_dn(input logic [3:0] d);
    return d == BCD_MIN;
  endfunction

  // Direction-aware ripple condition; an invalid nibble never ripples.
  function automatic logic ripple(input logic [3:0] d, input logic up);
    return up ? carry_up(d) : borrow_dn(d);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - count-step prescaler, holds its value while not running
module tick_gen #(
  parameter int TICK_DIV = 100_000
) (
  input  logic clk_div,
  input  logic rst_n,
  input  logic run,
  input  logic sclr,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = run & (cnt == LAST);

  // Prescaler: cleared on request, advances only while running, wraps after the terminal count.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (sclr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_chain_ctrl.sv
// rtl/bcd_chain_ctrl.sv - sequencing controller for a chain of BCD up/down digit counters
module bcd_chain_ctrl import bcd_pkg::*; #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100_000
) (
  input  logic                  clk_div,
  input  logic                  BTN0,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clr,
  input  logic                  dir_bit,
  input  logic                  hold_at_limit,
  input  logic [4*DIGITS-1:0]   digits_in,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  cnt_dir,
  output logic                  cnt_clr,
  output logic                  running,
  output logic                  wrap,
  output logic                  done,
  output logic                  bcd_err
);

  logic start_q, stop_q, clr_q;
  logic start_ev, stop_ev, clr_ev;

  state_t state, state_nxt;

  logic tick, step, sclr;
  logic [3:0] dig [DIGITS];
  logic at_limit, nib_bad;
  logic [DIGITS-1:0] en_chain;

  logic [DIGITS-1:0] en_nxt;
  logic wrap_nxt, dir_nxt, err_nxt;

  // Edge-detect history; reset to 0 so a level held through reset release reads as an edge.
  always_ff @(posedge clk_div or negedge BTN0) begin
    if (!BTN0) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      clr_q   <= clr;
    end
  end

  assign start_ev = start & ~start_q;
  assign stop_ev  = stop & ~stop_q;
  assign clr_ev   = clr & ~clr_q;

  // A fresh run from IDLE restarts the prescaler; resuming from PAUSE keeps its held value.
  assign sclr = clr_ev | ((state == IDLE) & start_ev);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_div (clk_div),
    .rst_n   (BTN0),
    .run     (state == RUN),
    .sclr    (sclr),
    .tick    (tick)
  );

  // A stop or clear edge in the terminal-count cycle swallows that step.
  assign step = tick & ~stop_ev & ~clr_ev;

  // Limit detection, invalid-nibble detection and the carry/borrow enable ripple.
  always_comb begin
    at_limit = 1'b1;
    nib_bad  = 1'b0;
    en_chain = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig[i]   = digits_in[4*i +: 4];
      at_limit = at_limit & ripple(dig[i], dir_bit);
      nib_bad  = nib_bad | (dig[i] > BCD_MAX);
    end
    en_chain[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      en_chain[i] = en_chain[i-1] & ripple(dig[i-1], dir_bit);
    end
  end

  // State register.
  always_ff @(posedge clk_div or negedge BTN0) begin
    if (!BTN0) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: clear overrides everything, then stop, then start; DONE leaves only via clear.
  always_comb begin
    state_nxt = state;
    if (clr_ev) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_ev) state_nxt = RUN;
        RUN: begin
          if (stop_ev)                                   state_nxt = PAUSE;
          else if (step && at_limit && hold_at_limit)    state_nxt = DONE;
        end
        PAUSE:   if (start_ev) state_nxt = RUN;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode: next values of the registered strobes, direction and error flag.
  always_comb begin
    en_nxt   = '0;
    wrap_nxt = 1'b0;
    dir_nxt  = cnt_dir;
    err_nxt  = bcd_err;
    if (clr_ev) begin
      err_nxt = 1'b0;
    end else if (step) begin
      dir_nxt = dir_bit;
      if (nib_bad) err_nxt = 1'b1;
      if (!(at_limit && hold_at_limit)) begin
        en_nxt   = en_chain;
        wrap_nxt = at_limit;
      end
    end
  end

  // Output registers: all strobes are single-cycle and launched one cycle after their cause.
  always_ff @(posedge clk_div or negedge BTN0) begin
    if (!BTN0) begin
      digit_en <= '0;
      wrap     <= 1'b0;
      cnt_dir  <= 1'b1;
      cnt_clr  <= 1'b0;
      bcd_err  <= 1'b0;
    end else begin
      digit_en <= en_nxt;
      wrap     <= wrap_nxt;
      cnt_dir  <= dir_nxt;
      cnt_clr  <= clr_ev;
      bcd_err  <= err_nxt;
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_bcd_chain_ctrl.sv
// tb/tb_bcd_chain_ctrl.sv - directed self-checking bench for bcd_chain_ctrl with a two-digit counter model
module tb_bcd_chain_ctrl;

  logic       clk_div;
  logic       BTN0;
  logic       start, stop, clr, dir_bit, hold_at_limit;
  logic [7:0] digits_in;
  logic [1:0] digit_en;
  logic       cnt_dir, cnt_clr, running, wrap, done, bcd_err;

  logic [3:0] d0, d1;
  logic       load_req;
  logic [7:0] load_v;

  int checks = 0;
  int errors = 0;

  bcd_chain_ctrl #(
    .DIGITS   (2),
    .TICK_DIV (4)
  ) dut (
    .clk_div       (clk_div),
    .BTN0          (BTN0),
    .start         (start),
    .stop          (stop),
    .clr           (clr),
    .dir_bit       (dir_bit),
    .hold_at_limit (hold_at_limit),
    .digits_in     (digits_in),
    .digit_en      (digit_en),
    .cnt_dir       (cnt_dir),
    .cnt_clr       (cnt_clr),
    .running       (running),
    .wrap          (wrap),
    .done          (done),
    .bcd_err       (bcd_err)
  );

  initial clk_div = 1'b0;
  always #5 clk_div = ~clk_div;

  function automatic logic [3:0] nxt(input logic [3:0] d, input logic up);
    if (up) return (d == 4'd9) ? 4'd0 : d + 4'd1;
    else    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  // Two digit counters driven by the controller, with a bench-side load for directed setups.
  always @(posedge clk_div or negedge BTN0) begin
    if (!BTN0) begin
      d0 <= 4'd0;
      d1 <= 4'd0;
    end else if (load_req) begin
      d1 <= load_v[7:4];
      d0 <= load_v[3:0];
    end else if (cnt_clr) begin
      d0 <= 4'd0;
      d1 <= 4'd0;
    end else begin
      if (digit_en[0]) d0 <= nxt(d0, cnt_dir);
      if (digit_en[1]) d1 <= nxt(d1, cnt_dir);
    end
  end

  assign digits_in = {d1, d0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk_div);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_div);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk_div);
    stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk_div);
    clr = 1'b0;
  endtask

  task automatic load(input logic [7:0] v);
    load_v   = v;
    load_req = 1'b1;
    @(negedge clk_div);
    load_req = 1'b0;
  endtask

  initial begin
    BTN0 = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0;
    dir_bit = 1'b1; hold_at_limit = 1'b0; load_req = 1'b0; load_v = 8'h00;
    nclk(2);
    chk("rst_en",      digit_en, 2'b00);
    chk("rst_dir",     cnt_dir,  1'b1);
    chk("rst_clr",     cnt_clr,  1'b0);
    chk("rst_running", running,  1'b0);
    chk("rst_wrap",    wrap,     1'b0);
    chk("rst_done",    done,     1'b0);
    chk("rst_err",     bcd_err,  1'b0);
    BTN0 = 1'b1;
    nclk(1);

    // Count up from 00: first enable 5 cycles after the start edge, then every 4.
    pulse_start();
    chk("run_after_start", running, 1'b1);
    for (int j = 0; j < 4; j++) begin
      chk("first_latency_quiet", digit_en, 2'b00);
      nclk(1);
    end
    for (int k = 0; k < 9; k++) begin
      chk("up_step_en", digit_en, 2'b01);
      chk("up_step_dir", cnt_dir, 1'b1);
      for (int j = 0; j < 3; j++) begin
        nclk(1);
        chk("up_between", digit_en, 2'b00);
      end
      nclk(1);
    end
    chk("carry_09_en", digit_en, 2'b11);
    nclk(1);
    chk("chain_10", digits_in, 8'h10);

    // Wrap at 99 without hold.
    load(8'h99);
    nclk(2);
    chk("wrap_en", digit_en, 2'b11);
    chk("wrap_pulse", wrap, 1'b1);
    nclk(1);
    chk("wrap_one_cycle", wrap, 1'b0);
    chk("wrap_en_off", digit_en, 2'b00);
    chk("chain_00", digits_in, 8'h00);

    // Hold at 99: no enables, DONE.
    hold_at_limit = 1'b1;
    load(8'h99);
    nclk(2);
    chk("hold_no_en", digit_en, 2'b00);
    chk("hold_done", done, 1'b1);
    chk("hold_not_running", running, 1'b0);
    chk("hold_no_wrap", wrap, 1'b0);

    // Clear out of DONE.
    pulse_clr();
    chk("clr_strobe", cnt_clr, 1'b1);
    chk("clr_done_low", done, 1'b0);
    chk("clr_idle", running, 1'b0);
    nclk(1);
    chk("clr_strobe_single", cnt_clr, 1'b0);
    chk("clr_chain_00", digits_in, 8'h00);
    hold_at_limit = 1'b0;

    // Count down from 10, then flip direction between steps.
    load(8'h10);
    dir_bit = 1'b0;
    pulse_start();
    nclk(4);
    chk("down_borrow_en", digit_en, 2'b11);
    chk("down_dir", cnt_dir, 1'b0);
    nclk(1);
    chk("down_chain_09", digits_in, 8'h09);
    dir_bit = 1'b1;
    nclk(2);
    chk("dir_holds_between", cnt_dir, 1'b0);
    nclk(1);
    chk("dir_flip_en", digit_en, 2'b11);
    chk("dir_flip_dir", cnt_dir, 1'b1);

    // Pause mid-count, resume finishes the remaining prescaler cycles.
    nclk(1);
    pulse_stop();
    chk("pause_not_running", running, 1'b0);
    for (int j = 0; j < 5; j++) begin
      chk("pause_no_en", digit_en, 2'b00);
      nclk(1);
    end
    pulse_start();
    chk("resume_quiet1", digit_en, 2'b00);
    chk("resume_running", running, 1'b1);
    nclk(1);
    chk("resume_quiet2", digit_en, 2'b00);
    nclk(1);
    chk("resume_en", digit_en, 2'b01);

    // Clear coincident with a step.
    nclk(3);
    clr = 1'b1;
    nclk(1);
    clr = 1'b0;
    chk("clr_step_no_en", digit_en, 2'b00);
    chk("clr_step_strobe", cnt_clr, 1'b1);
    chk("clr_step_idle", running, 1'b0);
    nclk(1);
    chk("clr_step_no_en2", digit_en, 2'b00);
    chk("clr_step_strobe_off", cnt_clr, 1'b0);
    chk("clr_step_chain", digits_in, 8'h00);

    // Clear and start edges together from IDLE.
    clr = 1'b1;
    start = 1'b1;
    nclk(1);
    clr = 1'b0;
    start = 1'b0;
    chk("clr_start_strobe", cnt_clr, 1'b1);
    chk("clr_start_idle", running, 1'b0);
    nclk(1);
    chk("clr_start_strobe_off", cnt_clr, 1'b0);
    for (int j = 0; j < 6; j++) begin
      chk("clr_start_no_en", digit_en, 2'b00);
      nclk(1);
    end

    // Invalid nibble: sticky error, no carry out of the bad digit.
    load(8'h0C);
    pulse_start();
    nclk(4);
    chk("bad_nib_en", digit_en, 2'b01);
    chk("bad_nib_err", bcd_err, 1'b1);
    nclk(4);
    chk("bad_nib_sticky", bcd_err, 1'b1);
    chk("bad_nib_en2", digit_en, 2'b01);
    pulse_clr();
    chk("bad_nib_cleared", bcd_err, 1'b0);

    // Asynchronous reset in the middle of an active step.
    load(8'h0C);
    dir_bit = 1'b0;
    pulse_start();
    nclk(4);
    chk("pre_rst_en", digit_en, 2'b01);
    chk("pre_rst_dir", cnt_dir, 1'b0);
    chk("pre_rst_err", bcd_err, 1'b1);
    chk("pre_rst_running", running, 1'b1);
    #2 BTN0 = 1'b0;
    #1;
    chk("arst_en", digit_en, 2'b00);
    chk("arst_dir", cnt_dir, 1'b1);
    chk("arst_err", bcd_err, 1'b0);
    chk("arst_running", running, 1'b0);
    chk("arst_wrap", wrap, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_clr", cnt_clr, 1'b0);
    nclk(1);
    BTN0 = 1'b1;
    nclk(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
